// File: rtl/nand_logic_unit_if.sv
// Stream interface for nand_logic_unit: operand beat channel in, result channel out.
interface nand_logic_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             accum;
  logic             in_last;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, op, accum, in_last, a, b, out_ready,
    input  in_ready, out_valid, y, out_count
  );

  modport slave (
    input  in_valid, op, accum, in_last, a, b, out_ready,
    output in_ready, out_valid, y, out_count
  );
endinterface

// File: rtl/nand_logic_unit.sv
// Registered WIDTH-bit logic unit built only from 2-input NAND primitives,
// with a valid/ready stream interface and a multi-beat reduction mode.
module nand_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  nand_logic_unit_if.slave  bus
);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {IDLE, ACCUM} state_t;

  // The single primitive; every other gate is composed from it.
  function automatic word_t g_nand(input word_t x, input word_t z);
    return ~(x & z);
  endfunction

  function automatic word_t g_not(input word_t x);
    return g_nand(x, x);
  endfunction

  function automatic word_t g_and(input word_t x, input word_t z);
    return g_not(g_nand(x, z));
  endfunction

  function automatic word_t g_or(input word_t x, input word_t z);
    return g_nand(g_not(x), g_not(z));
  endfunction

  function automatic word_t g_xor(input word_t x, input word_t z);
    word_t t;
    t = g_nand(x, z);
    return g_nand(g_nand(x, t), g_nand(z, t));
  endfunction

  function automatic word_t op_apply(input logic [2:0] o, input word_t x, input word_t z);
    word_t r;
    r = '0;
    case (o)
      3'b000: r = g_and(x, z);
      3'b001: r = g_or(x, z);
      3'b010: r = g_nand(x, z);
      3'b011: r = g_not(g_or(x, z));
      3'b100: r = g_xor(x, z);
      3'b101: r = g_not(g_xor(x, z));
      3'b110: r = g_not(x);
      3'b111: r = g_not(g_not(x));
    endcase
    return r;
  endfunction

  // Fold one beat into the running reduction; NOT/BUF just track the latest a.
  function automatic word_t base_fold(input logic [2:0] o, input word_t acc_v, input word_t x);
    word_t r;
    r = x;
    case (o)
      3'b000, 3'b010: r = g_and(acc_v, x);
      3'b001, 3'b011: r = g_or(acc_v, x);
      3'b100, 3'b101: r = g_xor(acc_v, x);
      default:        r = x;
    endcase
    return r;
  endfunction

  // Inverting ops invert the final base reduction rather than chaining.
  function automatic word_t finish(input logic [2:0] o, input word_t r);
    word_t f;
    f = r;
    case (o)
      3'b010, 3'b011, 3'b101, 3'b110: f = g_not(r);
      3'b111:                         f = g_not(g_not(r));
      default:                        f = r;
    endcase
    return f;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  state_t     state, state_n;
  word_t      acc, acc_n;
  cnt_t       cnt, cnt_n;
  logic [2:0] op_q, op_n;
  logic       out_valid, out_valid_n;
  word_t      y, y_n;
  cnt_t       out_count, out_count_n;
  word_t      folded;
  logic       in_ready;
  logic       fire;

  assign in_ready      = !out_valid || bus.out_ready;
  assign fire          = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y;
  assign bus.out_count = out_count;

  // Next-state, accumulator and output-register selection.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    op_n        = op_q;
    out_valid_n = out_valid;
    y_n         = y;
    out_count_n = out_count;
    folded      = base_fold(op_q, acc, bus.a);

    if (out_valid && bus.out_ready) out_valid_n = 1'b0;

    if (fire) begin
      if (state == IDLE) begin
        if (!bus.accum) begin
          y_n         = op_apply(bus.op, bus.a, bus.b);
          out_count_n = CNT_W'(1);
          out_valid_n = 1'b1;
        end else if (bus.in_last) begin
          y_n         = finish(bus.op, bus.a);
          out_count_n = CNT_W'(1);
          out_valid_n = 1'b1;
        end else begin
          state_n = ACCUM;
          op_n    = bus.op;
          acc_n   = bus.a;
          cnt_n   = CNT_W'(1);
        end
      end else begin
        if (bus.in_last) begin
          y_n         = finish(op_q, folded);
          out_count_n = sat_inc(cnt);
          out_valid_n = 1'b1;
          state_n     = IDLE;
        end else begin
          acc_n = folded;
          cnt_n = sat_inc(cnt);
        end
      end
    end
  end

  // State and datapath registers; reset discards any sequence or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      out_valid <= out_valid_n;
      y         <= y_n;
      out_count <= out_count_n;
    end
  end

endmodule

// File: tb/tb_nand_logic_unit.sv
// Scoreboard bench for nand_logic_unit (WIDTH=8, CNT_W=2).
module tb_nand_logic_unit;

  typedef struct {
    logic [7:0] y;
    logic [1:0] cnt;
    int         issue;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  bit   pending_seen;
  int   first_seen;

  nand_logic_unit_if #(.WIDTH(8), .CNT_W(2)) bus ();

  nand_logic_unit #(.WIDTH(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [2:0] op_i, input logic accum_i, input logic last_i,
                      input logic [7:0] a_i, input logic [7:0] b_i,
                      input bit expect_out, input logic [7:0] ey, input logic [1:0] ec);
    int w;
    @(posedge clk);
    #1;
    bus.op       = op_i;
    bus.accum    = accum_i;
    bus.in_last  = last_i;
    bus.a        = a_i;
    bus.b        = b_i;
    bus.in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=in_ready_low required=accept_within_50");
        bus.in_valid = 1'b0;
        return;
      end
    end
    if (expect_out) sb.push_back('{y: ey, cnt: ec, issue: cyc});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.b        = 8'hxx;
  endtask

  // Monitor: pop and compare on every output transfer.
  initial begin
    exp_t e;
    pending_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid && !pending_seen) begin
          pending_seen = 1'b1;
          first_seen   = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", bus.y);
          end else begin
            e = sb.pop_front();
            check("y", 32'(bus.y), 32'(e.y));
            check("out_count", 32'(bus.out_count), 32'(e.cnt));
            check("latency", 32'(first_seen - e.issue), 32'd1);
          end
          pending_seen = 1'b0;
        end
      end
    end
  end

  logic [7:0] exp_tbl [8];

  initial begin
    int w;
    exp_tbl = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hC3};
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.accum     = 1'b0;
    bus.in_last   = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Direct ops
    for (int i = 0; i < 8; i++)
      send(3'(i), 1'b0, 1'b0, 8'hC3, 8'hA5, 1'b1, exp_tbl[i], 2'd1);

    // Backpressure: hold for three cycles, then drain and accept in the same cycle
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(3'b100, 1'b0, 1'b0, 8'h3C, 8'h0F, 1'b1, 8'h33, 2'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_y", 32'(bus.y), 32'h33);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    fork
      send(3'b000, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 2'd1);
      begin
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join

    // NOR reduction; middle beat carries different op/accum that must be ignored
    send(3'b011, 1'b1, 1'b0, 8'h01, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b000, 1'b0, 1'b0, 8'h02, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b011, 1'b1, 1'b1, 8'h80, 8'hxx, 1'b1, 8'h7C, 2'd3);

    // Single-beat XNOR, two-beat XOR, AND and NOT reductions
    send(3'b101, 1'b1, 1'b1, 8'h0F, 8'hxx, 1'b1, 8'hF0, 2'd1);
    send(3'b100, 1'b1, 1'b0, 8'hFF, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b100, 1'b1, 1'b1, 8'h0F, 8'hxx, 1'b1, 8'hF0, 2'd2);
    send(3'b000, 1'b1, 1'b0, 8'hF0, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b000, 1'b1, 1'b1, 8'h3C, 8'hxx, 1'b1, 8'h30, 2'd2);
    send(3'b110, 1'b1, 1'b0, 8'h12, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b110, 1'b1, 1'b1, 8'h34, 8'hxx, 1'b1, 8'hCB, 2'd2);

    // Saturating count: six OR beats
    send(3'b001, 1'b1, 1'b0, 8'h01, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b001, 1'b1, 1'b0, 8'h02, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b001, 1'b1, 1'b0, 8'h04, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b001, 1'b1, 1'b0, 8'h08, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b001, 1'b1, 1'b0, 8'h10, 8'hxx, 1'b0, 8'h00, 2'd0);
    send(3'b001, 1'b1, 1'b1, 8'h20, 8'hxx, 1'b1, 8'h3F, 2'd3);

    // Reset while a result is held
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(3'b001, 1'b0, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_y", 32'(bus.y), 32'd0);
    check("async_rst_count", 32'(bus.out_count), 32'd0);
    sb.delete();
    pending_seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Reset mid-sequence: next direct beat must not be folded
    send(3'b001, 1'b1, 1'b0, 8'hFF, 8'hxx, 1'b0, 8'h00, 2'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    pending_seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(3'b000, 1'b0, 1'b0, 8'hC3, 8'hA5, 1'b1, 8'h81, 2'd1);

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
